spi_cmd_rx: RTL

//  SPI slave receiver and command parser on the PMOD link. Host drives sclk_pmod/mosi/cs_n.

---
 rtl/spi_cmd_rx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_rx.sv
// PMOD SPI slave: oversamples sclk/mosi/cs_n in the clk domain, deserialises bytes MSB-first
// and parses init/frame commands. Frame payloads are handed off with a valid/ready handshake.
module spi_cmd_rx #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [7:0]  HDR_INIT      = 8'h00,
  parameter logic [7:0]  HDR_FRAME     = 8'h01,
  parameter int          ERR_CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk_pmod,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         init_pulse,
  output logic [8*PAYLOAD_BYTES-1:0]   frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         busy,
  output logic [ERR_CNT_W-1:0]         err_cnt
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == ERR_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERR_CNT_W'(1);
    end
  endfunction

  logic [SYNC_STAGES-1:0]       sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]       mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]       cs_sync_q, cs_sync_d;
  logic                         sclk_prev_q, sclk_prev_d;
  logic [6:0]                   shift_q, shift_d;
  logic [2:0]                   bit_cnt_q, bit_cnt_d;
  logic [7:0]                   byte_q, byte_d;
  logic                         byte_done_q, byte_done_d;
  logic [1:0]                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [8*PAYLOAD_BYTES-1:0]   frame_data_q, frame_data_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         init_pulse_q, init_pulse_d;
  logic [ERR_CNT_W-1:0]         err_cnt_q, err_cnt_d;
  logic                         busy_q, busy_d;

  logic sclk_s, mosi_s, cs_s, sclk_fall_s, err_inc_s;

  // Synchroniser chains for the three asynchronous pins.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_pmod};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
  end

  // Byte deserialiser: sample mosi on synchronised sclk falling edges while selected.
  always_comb begin
    sclk_prev_d = sclk_s;
    sclk_fall_s = sclk_prev_q & ~sclk_s & ~cs_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    byte_done_d = 1'b0;
    if (cs_s) begin
      shift_d   = 7'd0;
      bit_cnt_d = 3'd0;
    end else if (sclk_fall_s) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d      = {shift_q, mosi_s};
        byte_done_d = 1'b1;
      end else begin
        byte_d      = byte_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Command parser FSM and payload assembly.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    init_pulse_d  = 1'b0;
    err_inc_s     = 1'b0;
    case (state_q)
      S_HDR: begin
        if (byte_done_q) begin
          if (byte_q == HDR_INIT) begin
            init_pulse_d = 1'b1;
          end else if (byte_q == HDR_FRAME) begin
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            err_inc_s = 1'b1;
            state_d   = S_DRAIN;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAYLOAD: begin
        if (byte_done_q) begin
          // idx 0 lands in the most significant byte lane.
          for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
              frame_data_d[(PAYLOAD_BYTES-1-b)*8 +: 8] = byte_q;
            end else begin
              frame_data_d[(PAYLOAD_BYTES-1-b)*8 +: 8] = frame_data_d[(PAYLOAD_BYTES-1-b)*8 +: 8];
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d         = '0;
            frame_valid_d = 1'b1;
            state_d       = S_HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_HOLD: begin
        if (frame_valid_q && frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = S_HDR;
        end else begin
          state_d = S_HOLD;
        end
        if (byte_done_q) begin
          err_inc_s = 1'b1;
        end else begin
          err_inc_s = 1'b0;
        end
      end
      S_DRAIN: begin
        if (cs_s) begin
          state_d = S_HDR;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d       = S_HDR;
        frame_valid_d = 1'b0;
      end
    endcase
    if (err_inc_s) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
    busy_d = (state_d != S_HDR) || (bit_cnt_d != 3'd0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q   <= {SYNC_STAGES{1'b0}};
      mosi_sync_q   <= {SYNC_STAGES{1'b0}};
      cs_sync_q     <= {SYNC_STAGES{1'b1}};
      sclk_prev_q   <= 1'b0;
      shift_q       <= 7'd0;
      bit_cnt_q     <= 3'd0;
      byte_q        <= 8'd0;
      byte_done_q   <= 1'b0;
      state_q       <= S_HDR;
      idx_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      init_pulse_q  <= 1'b0;
      err_cnt_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_q        <= byte_d;
      byte_done_q   <= byte_done_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      init_pulse_q  <= init_pulse_d;
      err_cnt_q     <= err_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign init_pulse  = init_pulse_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;

endmodule
